// File: rtl/spi_regfile_pkg.sv
// Shared types and command-format constants for the SPI register-file slave.
package spi_regfile_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        CMD   = 3'd1,
        WDATA = 3'd2,
        RDATA = 3'd3,
        DONE  = 3'd4
    } state_t;

    localparam int CMD_W  = 8;
    localparam int RW_BIT = 7;
    localparam int ADDR_W = 7;

endpackage

// File: rtl/spi_edge_sync.sv
// Two-flop synchroniser for an asynchronous SPI line, with rise/fall strobes
// derived from the synchronised samples. RST_LVL is the idle level of the line.
module spi_edge_sync #(
    parameter logic RST_LVL = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic rise,
    output logic fall
);

    // [0],[1] form the synchroniser; [2] holds the previous synchronised sample.
    logic [2:0] sync_sr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_sr <= {3{RST_LVL}};
        end else begin
            sync_sr <= {sync_sr[1:0], din};
        end
    end

    assign rise = sync_sr[1] & ~sync_sr[2];
    assign fall = ~sync_sr[1] & sync_sr[2];

endmodule

// File: rtl/spi_regfile_slave.sv
// SPI slave giving access to a read/write register file and a read-only status window.
// Define SPI_REGFILE_BURST_EN to auto-increment the address across words in one frame.
module spi_regfile_slave
    import spi_regfile_pkg::*;
#(
    parameter int                DATA_W   = 16,
    parameter int                NUM_REGS = 32,
    parameter int                RO_BASE  = 64,
    parameter int                NUM_RO   = 2,
    parameter logic [DATA_W-1:0] RST_VAL  = '0
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       SCK,
    input  logic                       CS,
    input  logic                       MOSI,
    output logic                       MISO,
    output logic [NUM_REGS*DATA_W-1:0] regs_o,
    input  logic [NUM_RO*DATA_W-1:0]   ro_in,
    output logic                       wr_pulse,
    output logic [ADDR_W-1:0]          wr_addr
);

    localparam int             CNT_W    = 6;
    localparam logic [CNT_W-1:0] CMD_CNT  = CNT_W'(CMD_W);
    localparam logic [CNT_W-1:0] WORD_CNT = CNT_W'(DATA_W);

    logic sck_rise, sck_fall, cs_rise, cs_fall;
    logic [1:0] mosi_sr;
    logic       mosi_s;

    state_t             state, state_nxt;
    logic [CNT_W-1:0]   cnt;
    logic [CMD_W-1:0]   cmd_sr;
    logic [ADDR_W-1:0]  addr, ld_addr;
    logic [DATA_W-1:0]  wr_sr, rd_sr;
    logic [DATA_W-1:0]  regs [NUM_REGS];

    logic cnt_clr, cnt_inc, cmd_shift, addr_load, addr_inc;
    logic wr_shift, rd_shift, rd_load, commit;

    spi_edge_sync #(.RST_LVL(1'b0)) u_sck_sync (
        .clk(clk), .rst_n(rst_n), .din(SCK), .rise(sck_rise), .fall(sck_fall)
    );

    spi_edge_sync #(.RST_LVL(1'b1)) u_cs_sync (
        .clk(clk), .rst_n(rst_n), .din(CS), .rise(cs_rise), .fall(cs_fall)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) mosi_sr <= 2'b00;
        else        mosi_sr <= {mosi_sr[0], MOSI};
    end
    assign mosi_s = mosi_sr[1];

    function automatic logic is_rw(input logic [ADDR_W-1:0] a);
        logic hit;
        hit = 1'b0;
        for (int k = 0; k < NUM_REGS; k++) if (a == ADDR_W'(k)) hit = 1'b1;
        return hit;
    endfunction

    function automatic logic [DATA_W-1:0] read_word(input logic [ADDR_W-1:0] a);
        logic [DATA_W-1:0] w;
        w = '0;
        for (int k = 0; k < NUM_REGS; k++) if (a == ADDR_W'(k)) w = regs[k];
        for (int k = 0; k < NUM_RO; k++)
            if (a == ADDR_W'(RO_BASE + k)) w = ro_in[k*DATA_W +: DATA_W];
        return w;
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // Phases finish one clk after their last SCK rise (cnt reaching the phase length).
    // In RDATA the first SCK fall after the command must keep the already-presented MSB,
    // so shifting only starts once a data bit has been clocked (cnt != 0).
    always_comb begin
        state_nxt = state;
        cnt_clr   = 1'b0;
        cnt_inc   = 1'b0;
        cmd_shift = 1'b0;
        addr_load = 1'b0;
        addr_inc  = 1'b0;
        wr_shift  = 1'b0;
        rd_shift  = 1'b0;
        rd_load   = 1'b0;
        commit    = 1'b0;
        ld_addr   = (state == CMD) ? cmd_sr[ADDR_W-1:0] : addr + 1'b1;
        case (state)
            IDLE: begin
                if (cs_fall) begin
                    state_nxt = CMD;
                    cnt_clr   = 1'b1;
                end
            end
            CMD: begin
                if (cnt == CMD_CNT) begin
                    cnt_clr   = 1'b1;
                    addr_load = 1'b1;
                    if (cmd_sr[RW_BIT]) begin
                        state_nxt = WDATA;
                    end else begin
                        state_nxt = RDATA;
                        rd_load   = 1'b1;
                    end
                end else if (sck_rise) begin
                    cmd_shift = 1'b1;
                    cnt_inc   = 1'b1;
                end
            end
            WDATA: begin
                if (cnt == WORD_CNT) begin
                    commit = 1'b1;
`ifdef SPI_REGFILE_BURST_EN
                    addr_inc = 1'b1;
                    cnt_clr  = 1'b1;
`else
                    state_nxt = DONE;
`endif
                end else if (sck_rise) begin
                    wr_shift = 1'b1;
                    cnt_inc  = 1'b1;
                end
            end
            RDATA: begin
                if (cnt == WORD_CNT) begin
`ifdef SPI_REGFILE_BURST_EN
                    addr_inc = 1'b1;
                    rd_load  = 1'b1;
                    cnt_clr  = 1'b1;
`else
                    state_nxt = DONE;
`endif
                end else if (sck_rise) begin
                    cnt_inc = 1'b1;
                end else if (sck_fall && cnt != '0) begin
                    rd_shift = 1'b1;
                end
            end
            DONE: ;
            default: state_nxt = IDLE;
        endcase
        if (cs_rise) state_nxt = IDLE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt    <= '0;
            cmd_sr <= '0;
            addr   <= '0;
            wr_sr  <= '0;
            rd_sr  <= '0;
        end else begin
            if (cnt_clr)      cnt <= '0;
            else if (cnt_inc) cnt <= cnt + 1'b1;
            if (cmd_shift) cmd_sr <= {cmd_sr[CMD_W-2:0], mosi_s};
            if (addr_load)     addr <= cmd_sr[ADDR_W-1:0];
            else if (addr_inc) addr <= addr + 1'b1;
            if (wr_shift) wr_sr <= {wr_sr[DATA_W-2:0], mosi_s};
            if (rd_load)       rd_sr <= read_word(ld_addr);
            else if (rd_shift) rd_sr <= {rd_sr[DATA_W-2:0], 1'b0};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < NUM_REGS; k++) regs[k] <= RST_VAL;
            wr_pulse <= 1'b0;
            wr_addr  <= '0;
        end else begin
            wr_pulse <= commit && is_rw(addr);
            if (commit && is_rw(addr)) wr_addr <= addr;
            for (int k = 0; k < NUM_REGS; k++)
                if (commit && addr == ADDR_W'(k)) regs[k] <= wr_sr;
        end
    end

    for (genvar k = 0; k < NUM_REGS; k++) begin : g_flat
        assign regs_o[k*DATA_W +: DATA_W] = regs[k];
    end

    assign MISO = (state == RDATA) ? rd_sr[DATA_W-1] : 1'bz;

endmodule
